// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: in-order command buffer in front of the 4-bit barrel shifter.
// Entries are {data, amt, dir, rot}. Reports occupancy and a sticky overflow flag.
// Optional build macro SHIFT_CMD_BYPASS_EN adds a zero-latency pass-through path
// when the queue is empty and the shifter is ready.
module shift_cmd_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_data,
   input  logic [1:0] cmd_amt,
   input  logic       cmd_dir,
   input  logic       cmd_rot,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_data,
   output logic [1:0] out_amt,
   output logic       out_dir,
   output logic       out_rot,
   output logic [3:0] count,
   output logic       ovf
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]    DEPTH_CNT = 4'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [3:0]    count_q, count_d;
   logic          ovf_q, ovf_d;

   logic       full, empty;
   logic       push, pop;
   logic       bypass;
   logic [7:0] cmd_entry;
   logic [7:0] head;

   assign cmd_entry = {cmd_data, cmd_amt, cmd_dir, cmd_rot};

   // Handshake, head selection and next-state decode.
   always_comb begin
      full      = (count_q == DEPTH_CNT);
      empty     = (count_q == 4'd0);
      // Held low during reset so upstream never sees a ready queue before release.
      cmd_ready = rst_n & ~full;
`ifdef SHIFT_CMD_BYPASS_EN
      // Empty queue with a ready shifter: the command flows through unstored.
      bypass    = rst_n & empty & cmd_valid & out_ready;
      out_valid = rst_n & (~empty | cmd_valid);
      head      = empty ? cmd_entry : mem_q[rd_ptr_q];
`else
      bypass    = 1'b0;
      out_valid = ~empty;
      head      = mem_q[rd_ptr_q];
`endif
      push = cmd_valid & cmd_ready & ~bypass;
      pop  = ~empty & out_ready;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase

      // A refused command is dropped; remember that it happened.
      ovf_d = ovf_q | (cmd_valid & ~cmd_ready);
   end

   // Head fields are zeroed whenever nothing is presented.
   always_comb begin
      out_data = 4'd0;
      out_amt  = 2'd0;
      out_dir  = 1'b0;
      out_rot  = 1'b0;
      if (out_valid) begin
         {out_data, out_amt, out_dir, out_rot} = head;
      end
   end

   assign count = count_q;
   assign ovf   = ovf_q;

   // Pointer, occupancy and overflow state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 4'd0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Entry storage; written only on an accepted push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= 8'd0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= cmd_entry;
      end
   end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Self-checking bench for shift_cmd_queue (DEPTH = 4) with a queue scoreboard.
module tb_shift_cmd_queue;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_data = 4'd0;
   logic [1:0] cmd_amt = 2'd0;
   logic       cmd_dir = 1'b0;
   logic       cmd_rot = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic [1:0] out_amt;
   logic       out_dir;
   logic       out_rot;
   logic [3:0] count;
   logic       ovf;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] exp_q [$];
   int         m_count = 0;
   logic       m_ovf = 1'b0;
   logic [7:0] head;

   assign head = {out_data, out_amt, out_dir, out_rot};

   shift_cmd_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_amt   (cmd_amt),
      .cmd_dir   (cmd_dir),
      .cmd_rot   (cmd_rot),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_amt   (out_amt),
      .out_dir   (out_dir),
      .out_rot   (out_rot),
      .count     (count),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input logic [7:0] e, input logic r);
      cmd_valid = v;
      {cmd_data, cmd_amt, cmd_dir, cmd_rot} = e;
      out_ready = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour for the coming edge (default, no-bypass semantics).
   task automatic model_edge(input logic v, input logic [7:0] e, input logic r);
      logic do_push, do_pop;
      do_push = v && (m_count < int'(DEPTH));
      do_pop  = r && (m_count > 0);
      if (v && !do_push) m_ovf = 1'b1;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(e);
      m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready);
      end
      tests_run++;
      if (out_valid !== 1'b0 || head !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_out: got valid=%b head=%h expected 0/00", out_valid, head);
      end
      tests_run++;
      if (count !== 4'd0 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_count_ovf: got %0d/%b expected 0/0", count, ovf);
      end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL release_cmd_ready: got %b expected 1", cmd_ready);
      end
      exp_q.delete();
      m_count = 0;
      m_ovf = 1'b0;
   endtask

   task automatic test_fill();
      logic [7:0] fill [4];
      fill[0] = {4'hA, 2'd1, 1'b0, 1'b0};
      fill[1] = {4'h5, 2'd2, 1'b1, 1'b1};
      fill[2] = {4'hF, 2'd3, 1'b0, 1'b1};
      fill[3] = {4'h0, 2'd0, 1'b1, 1'b0};
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, fill[i], 1'b0);
         @(negedge clk);
         tests_run++;
         if (cmd_ready !== 1'b1 || count !== 4'(m_count)) begin
            tests_failed++;
            $display("FAIL fill_push%0d: got ready=%b count=%0d expected 1/%0d",
                     i, cmd_ready, count, m_count);
         end
         model_edge(1'b1, fill[i], 1'b0);
         step();
      end
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      tests_run++;
      if (count !== 4'd4 || cmd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_full: got count=%0d ready=%b expected 4/0", count, cmd_ready);
      end
      tests_run++;
      if (out_valid !== 1'b1 || head !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL fill_head: got valid=%b head=%h expected 1/%h", out_valid, head, exp_q[0]);
      end
      step();
      drive(1'b1, 8'hC4, 1'b0);
      @(negedge clk);
      model_edge(1'b1, 8'hC4, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      tests_run++;
      if (ovf !== m_ovf || count !== 4'(m_count)) begin
         tests_failed++;
         $display("FAIL fill_overflow: got ovf=%b count=%0d expected %b/%0d",
                  ovf, count, m_ovf, m_count);
      end
   endtask

   task automatic test_drain();
      step();
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         @(negedge clk);
         tests_run++;
         if (out_valid !== 1'b1 || head !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL drain_head%0d: got valid=%b head=%h expected 1/%h",
                     i, out_valid, head, exp_q[0]);
         end
         model_edge(1'b0, 8'h00, 1'b1);
         step();
      end
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || head !== 8'h00 || count !== 4'd0) begin
         tests_failed++;
         $display("FAIL drain_empty: got valid=%b head=%h count=%0d expected 0/00/0",
                  out_valid, head, count);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      step();
      for (int i = 0; i < 2; i++) begin
         e = 8'(8'h31 + 8'(i * 17));
         drive(1'b1, e, 1'b0);
         @(negedge clk);
         model_edge(1'b1, e, 1'b0);
         step();
      end
      for (int i = 0; i < 6; i++) begin
         e = 8'($urandom_range(0, 255));
         drive(1'b1, e, 1'b1);
         @(negedge clk);
         tests_run++;
         if (count !== 4'd2 || cmd_ready !== 1'b1 || out_valid !== 1'b1 || head !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL b2b_cycle%0d: got count=%0d ready=%b valid=%b head=%h expected 2/1/1/%h",
                     i, count, cmd_ready, out_valid, head, exp_q[0]);
         end
         model_edge(1'b1, e, 1'b1);
         step();
      end
      drive(1'b0, 8'h00, 1'b0);
      test_drain();
   endtask

   task automatic test_full_both();
      logic [7:0] e;
      step();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 8'(8'h90 + 8'(i)), 1'b0);
         step();
      end
      drive(1'b0, 8'h00, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || count !== 4'd0 || cmd_ready !== 1'b0 || head !== 8'h00) begin
         tests_failed++;
         $display("FAIL midreset: got valid=%b count=%0d ready=%b head=%h expected 0/0/0/00",
                  out_valid, count, cmd_ready, head);
      end
      exp_q.delete();
      m_count = 0;
      m_ovf = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = 8'(8'h1B + 8'(i * 41));
         drive(1'b1, e, 1'b0);
         @(negedge clk);
         model_edge(1'b1, e, 1'b0);
         step();
      end
      drive(1'b1, 8'h77, 1'b1);
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b0 || ovf !== 1'b0 || head !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL fullboth_pre: got ready=%b ovf=%b head=%h expected 0/0/%h",
                  cmd_ready, ovf, head, exp_q[0]);
      end
      model_edge(1'b1, 8'h77, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      tests_run++;
      if (count !== 4'd3 || ovf !== 1'b1 || cmd_ready !== 1'b1 || head !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL fullboth_post: got count=%0d ovf=%b ready=%b head=%h expected 3/1/1/%h",
                  count, ovf, cmd_ready, head, exp_q[0]);
      end
      test_drain();
   endtask

   task automatic test_bypass();
      logic [7:0] e;
      e = {4'h9, 2'd1, 1'b1, 1'b1};
      step();
      drive(1'b1, e, 1'b1);
      @(negedge clk);
`ifdef SHIFT_CMD_BYPASS_EN
      tests_run++;
      if (out_valid !== 1'b1 || head !== e) begin
         tests_failed++;
         $display("FAIL bypass_same_cycle: got valid=%b head=%h expected 1/%h", out_valid, head, e);
      end
      step();
      drive(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      tests_run++;
      if (count !== 4'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bypass_after: got count=%0d valid=%b expected 0/0", count, out_valid);
      end
`else
      tests_run++;
      if (out_valid !== 1'b0 || head !== 8'h00) begin
         tests_failed++;
         $display("FAIL nobypass_same_cycle: got valid=%b head=%h expected 0/00", out_valid, head);
      end
      step();
      drive(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || head !== e || count !== 4'd1) begin
         tests_failed++;
         $display("FAIL nobypass_next: got valid=%b head=%h count=%0d expected 1/%h/1",
                  out_valid, head, count, e);
      end
      step();
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      tests_run++;
      if (count !== 4'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL nobypass_after: got count=%0d valid=%b expected 0/0", count, out_valid);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_full_both();
      test_bypass();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
